// File: rtl/i2s_player.sv
// i2s_player: streams 16-bit SRAM words to an I2S codec, one word per DACLRCK low half.
// Define PLAYER_LOOP_EN to wrap back to address 0 forever instead of finishing.
module i2s_player #(
  parameter int MAX_ADDR = 1048575
) (
  input  logic        i_BCLK,
  input  logic        i_rst_n,
  input  logic        i_play_start,
  input  logic        i_pause,
  input  logic        i_stop,
  input  logic [19:0] i_end_addr,
  input  logic        i_DACLRCK,
  input  logic [15:0] i_SRAM_DATA,
  output logic [19:0] o_SRAM_ADDR,
  output logic        o_SRAM_OE,
  output logic        o_SRAM_WE,
  output logic        o_DACDAT,
  output logic [2:0]  o_PLAY_STATE,
  output logic        o_finish
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [19:0] MAX_A = 20'(MAX_ADDR);
  logic [2:0]  state;
  logic [19:0] addr_r, end_r;
  logic [15:0] shift_r;
  logic [3:0]  bit_cnt;
  logic        pre_r, fall;
  assign fall = pre_r & ~i_DACLRCK;
  always_ff @(posedge i_BCLK) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      addr_r  <= '0;
      end_r   <= '0;
      shift_r <= '0;
      bit_cnt <= '0;
      pre_r   <= 1'b0;
    end else begin
      pre_r <= i_DACLRCK;
      if (i_stop) begin
        state  <= S_IDLE;
        addr_r <= '0;
      end else begin
        case (state)
          S_IDLE: if (i_play_start) begin
            state  <= S_WAIT;
            addr_r <= '0;
            end_r  <= (i_end_addr > MAX_A) ? MAX_A : i_end_addr;
          end
          S_WAIT: if (i_pause) state <= S_PAUSE;
          else if (fall) begin
            shift_r <= i_SRAM_DATA;
            bit_cnt <= '0;
            state   <= S_SEND;
          end
          S_SEND: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              if (addr_r == end_r) begin
`ifdef PLAYER_LOOP_EN
                addr_r <= '0;
                state  <= S_WAIT;
`else
                state  <= S_FINISH;
`endif
              end else begin
                addr_r <= addr_r + 20'd1;
                state  <= S_WAIT;
              end
            end
          end
          S_PAUSE:  if (!i_pause) state <= S_WAIT;
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end
  assign o_SRAM_ADDR  = addr_r;
  assign o_SRAM_OE    = state != S_WAIT;
  assign o_SRAM_WE    = 1'b1;
  assign o_DACDAT     = (state == S_SEND) & shift_r[bit_cnt];
  assign o_PLAY_STATE = state;
  assign o_finish     = state == S_FINISH;
endmodule

// File: tb/tb_i2s_player.sv
// tb_i2s_player: scoreboard bench; expected words queued by stimulus, monitor reassembles serial output.
module tb_i2s_player;
  logic        clk = 1'b0;
  logic        rst_n, play_start, pause, stop, lrck;
  logic [19:0] end_addr, addr;
  logic [15:0] sram_data;
  logic        oe, we, dac, fin;
  logic [2:0]  st;
  logic [15:0] mem [0:7];
  logic [15:0] exp_q [$];
  logic [15:0] sh;
  int n_cmp = 0, n_bad = 0, fin_cnt = 0, words_done = 0, bcnt = 0, lr_cnt = 0;
  always #5 clk = ~clk;
  assign sram_data = mem[addr[2:0]];
  i2s_player #(.MAX_ADDR(5)) dut (
    .i_BCLK(clk), .i_rst_n(rst_n), .i_play_start(play_start), .i_pause(pause),
    .i_stop(stop), .i_end_addr(end_addr), .i_DACLRCK(lrck), .i_SRAM_DATA(sram_data),
    .o_SRAM_ADDR(addr), .o_SRAM_OE(oe), .o_SRAM_WE(we), .o_DACDAT(dac),
    .o_PLAY_STATE(st), .o_finish(fin)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // codec word clock: 20 BCLK per half
  always @(negedge clk) begin
    lr_cnt++;
    if (lr_cnt == 20) begin
      lr_cnt = 0;
      lrck = ~lrck;
    end
  end
  always @(negedge clk) begin
    if (fin === 1'b1) fin_cnt++;
    if (st == 3'd2) begin
      sh[bcnt] = dac;
      bcnt++;
      if (bcnt == 16) begin
        bcnt = 0;
        words_done++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL word_unexpected: got %04h expected none", sh);
        end else chk("word", {16'h0, sh}, {16'h0, exp_q.pop_front()});
      end
    end else begin
      bcnt = 0;
      chk("dacdat_idle", {31'h0, dac}, 32'h0);
    end
  end
  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(mem[i]);
  endtask
  task automatic start(input logic [19:0] e);
    end_addr = e;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
  endtask
  task automatic wait_st(input string name, input logic [2:0] s, input int a);
    int i;
    for (i = 0; i < 3000 && !(st == s && (a < 0 || addr == 20'(a))); i++) @(negedge clk);
    chk(name, {31'h0, st == s && (a < 0 || addr == 20'(a))}, 32'h1);
  endtask
  task automatic wait_fin(input string name);
    int i;
    for (i = 0; i < 3000 && fin !== 1'b1; i++) @(negedge clk);
    chk(name, {31'h0, fin}, 32'h1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dac"}, {31'h0, dac}, 32'h0);
    chk({tag, "_fin"}, {31'h0, fin}, 32'h0);
    chk({tag, "_oe"}, {31'h0, oe}, 32'h1);
    chk({tag, "_we"}, {31'h0, we}, 32'h1);
    chk({tag, "_addr"}, {12'h0, addr}, 32'h0);
    chk({tag, "_state"}, {29'h0, st}, 32'h0);
  endtask
  initial begin
    int f0;
    mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hA5A5; mem[3] = 16'h1234;
    mem[4] = 16'h0F0F; mem[5] = 16'hFFFE; mem[6] = 16'h5555; mem[7] = 16'hC3C3;
    lrck = 1'b1; rst_n = 1'b0; play_start = 1'b0; pause = 1'b0; stop = 1'b0; end_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
`ifdef PLAYER_LOOP_EN
    f0 = fin_cnt;
    for (int k = 0; k < 3; k++) push_range(0, 1);
    start(20'd1);
    begin
      int w0, i;
      w0 = words_done;
      for (i = 0; i < 3000 && words_done < w0 + 6; i++) @(negedge clk);
      chk("loop_words", words_done - w0, 6);
    end
    chk("loop_no_finish", fin_cnt - f0, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("loop_stop_state", {29'h0, st}, 32'h0);
    chk("loop_stop_addr", {12'h0, addr}, 32'h0);
`else
    f0 = fin_cnt;
    push_range(0, 2);
    start(20'd2);
    wait_fin("t1_finish");
    repeat (3) @(negedge clk);
    chk("t1_fin_pulses", fin_cnt - f0, 1);
    chk("t1_state", {29'h0, st}, 32'h0);
    chk("t1_addr", {12'h0, addr}, 32'h2);
    f0 = fin_cnt;
    push_range(0, 3);
    start(20'd3);
    wait_st("t2_send_w1", 3'd2, 1);
    pause = 1'b1;
    wait_st("t2_pause", 3'd3, -1);
    chk("t2_pause_addr", {12'h0, addr}, 32'h2);
    repeat (50) @(negedge clk);
    chk("t2_pause_hold_state", {29'h0, st}, 32'h3);
    chk("t2_pause_hold_addr", {12'h0, addr}, 32'h2);
    pause = 1'b0;
    wait_fin("t2_finish");
    repeat (3) @(negedge clk);
    chk("t2_fin_pulses", fin_cnt - f0, 1);
    f0 = fin_cnt;
    push_range(0, 2);
    start(20'd5);
    wait_st("t3_send_w3", 3'd2, 3);
    repeat (7) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    chk("t3_state", {29'h0, st}, 32'h0);
    chk("t3_dac", {31'h0, dac}, 32'h0);
    chk("t3_addr", {12'h0, addr}, 32'h0);
    chk("t3_fin", {31'h0, fin}, 32'h0);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_no_finish", fin_cnt - f0, 0);
    push_range(0, 0);
    start(20'd3);
    wait_st("t4_send_w1", 3'd2, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t4_reset");
    rst_n = 1'b1;
    f0 = fin_cnt;
    push_range(0, 3);
    start(20'd3);
    wait_fin("t4_finish");
    repeat (3) @(negedge clk);
    chk("t4_fin_pulses", fin_cnt - f0, 1);
    f0 = fin_cnt;
    push_range(0, 0);
    start(20'd0);
    wait_fin("t5_finish");
    repeat (3) @(negedge clk);
    chk("t5_fin_pulses", fin_cnt - f0, 1);
    chk("t5_state", {29'h0, st}, 32'h0);
    chk("t5_addr", {12'h0, addr}, 32'h0);
    push_range(0, 5);
    start(20'd9);
    wait_fin("t6_finish");
    chk("t6_clamped_addr", {12'h0, addr}, 32'h5);
    repeat (3) @(negedge clk);
`endif
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
